// File: rtl/riscv_pkg.sv
// Shared core types: memory op encoding plus the unified-memory arbiter's state/owner enums.
package riscv;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned STREAK_W = 4;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [3:0] {
    LOAD_STORE_NONE    = 4'd0,
    LOAD_BYTE          = 4'd1,
    LOAD_BYTE_UNSIGNED = 4'd2,
    LOAD_HALF          = 4'd3,
    LOAD_HALF_UNSIGNED = 4'd4,
    LOAD_WORD          = 4'd5,
    STORE_BYTE         = 4'd6,
    STORE_HALF         = 4'd7,
    STORE_WORD         = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    ERR  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IMEM = 1'b0,
    OWN_DMEM = 1'b1
  } arb_owner_t;

  function automatic logic is_store(mem_op_t op);
    return op inside {STORE_BYTE, STORE_HALF, STORE_WORD};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane formatting for the unified memory port: strobes, store replication,
// misalignment detection and load extraction/extension.
module mem_align
  import riscv::*;
(
  input  mem_op_t     i_op,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  mem_op_t     i_rsp_op,
  input  logic [1:0]  i_rsp_lane,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_strb,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_rsp_lane, 3'b000};

  // Request side: lane strobes, replicated store data, alignment check.
  always_comb begin
    o_strb       = 4'b0000;
    o_wdata      = i_wdata;
    o_misaligned = 1'b0;
    case (i_op)
      LOAD_WORD, STORE_WORD: begin
        o_strb       = 4'b1111;
        o_misaligned = (i_lane != 2'b00);
      end
      LOAD_HALF, LOAD_HALF_UNSIGNED, STORE_HALF: begin
        o_strb       = 4'b0011 << i_lane;
        o_misaligned = i_lane[0];
      end
      LOAD_BYTE, LOAD_BYTE_UNSIGNED, STORE_BYTE: begin
        o_strb = 4'b0001 << i_lane;
      end
      default: ;
    endcase
    case (i_op)
      STORE_HALF: o_wdata = {2{i_wdata[15:0]}};
      STORE_BYTE: o_wdata = {4{i_wdata[7:0]}};
      default:    ;
    endcase
  end

  // Response side: stores and idle return zero.
  always_comb begin
    o_rdata = 32'h0;
    case (i_rsp_op)
      LOAD_BYTE:          o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LOAD_BYTE_UNSIGNED: o_rdata = {24'h0, w_shifted[7:0]};
      LOAD_HALF:          o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LOAD_HALF_UNSIGNED: o_rdata = {16'h0, w_shifted[15:0]};
      LOAD_WORD:          o_rdata = w_shifted;
      default:            ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported unified memory between fetch and data ports: data priority,
// fetch starvation guard, one access in flight, lane formatting and misalignment errors.
module mem_arbiter
  import riscv::*;
#(
  parameter int unsigned DMEM_STREAK = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic        imem_ready,
  output logic        imem_rvalid,
  output logic [31:0] imem_rdata,
  output logic        imem_error,
  input  mem_op_t     dmem_op,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_ready,
  output logic        dmem_rvalid,
  output logic [31:0] dmem_rdata,
  output logic        dmem_error,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [3:0]  mem_strb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  arb_state_t            r_state, w_state_nxt;
  arb_owner_t            r_owner, w_owner;
  mem_op_t               r_op, w_op;
  logic [1:0]            r_lane;
  logic [STREAK_W-1:0]   r_streak, w_streak_nxt;

  logic        w_dmem_req, w_sel_dmem, w_latch, w_accept, w_req, w_rsp, w_err;
  logic        w_misaligned;
  logic [3:0]  w_strb;
  logic [31:0] w_addr, w_wdata, w_rep, w_rdata_fmt;

  assign w_dmem_req = (dmem_op != LOAD_STORE_NONE);
  assign w_sel_dmem = w_dmem_req && !(imem_valid && (r_streak == STREAK_W'(DMEM_STREAK)));
  // Selection is live only in IDLE; afterwards the latched owner steers everything.
  assign w_owner    = (r_state == IDLE) ? (w_sel_dmem ? OWN_DMEM : OWN_IMEM) : r_owner;
  assign w_op       = (w_owner == OWN_DMEM) ? dmem_op : LOAD_WORD;
  assign w_addr     = (w_owner == OWN_DMEM) ? dmem_addr : imem_addr;
  assign w_wdata    = (w_owner == OWN_DMEM) ? dmem_wdata : 32'h0;

  mem_align u_align (
    .i_op        (w_op),
    .i_lane      (w_addr[1:0]),
    .i_wdata     (w_wdata),
    .i_rsp_op    (r_op),
    .i_rsp_lane  (r_lane),
    .i_rdata     (mem_rdata),
    .o_strb      (w_strb),
    .o_wdata     (w_rep),
    .o_misaligned(w_misaligned),
    .o_rdata     (w_rdata_fmt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_owner  <= OWN_IMEM;
      r_op     <= LOAD_STORE_NONE;
      r_lane   <= 2'b00;
      r_streak <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
      if (w_latch) begin
        r_owner <= w_owner;
        r_op    <= w_op;
        r_lane  <= w_addr[1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_latch      = 1'b0;
    w_accept     = 1'b0;
    w_req        = 1'b0;
    w_rsp        = 1'b0;
    w_err        = 1'b0;
    w_streak_nxt = r_streak;

    case (r_state)
      IDLE: begin
        if (imem_valid || w_dmem_req) begin
          w_latch = 1'b1;
          if (w_misaligned) begin
            w_accept    = 1'b1;
            w_state_nxt = ERR;
          end else begin
            w_req = 1'b1;
            if (mem_gnt) begin
              w_accept    = 1'b1;
              w_state_nxt = WAIT;
            end else begin
              w_state_nxt = REQ;
            end
          end
        end
      end
      REQ: begin
        w_req = 1'b1;
        if (mem_gnt) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          w_rsp       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      ERR: begin
        w_rsp       = 1'b1;
        w_err       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    imem_ready  = w_accept && (w_owner == OWN_IMEM);
    dmem_ready  = w_accept && (w_owner == OWN_DMEM);
    imem_rvalid = w_rsp && (r_owner == OWN_IMEM);
    dmem_rvalid = w_rsp && (r_owner == OWN_DMEM);
    imem_error  = imem_rvalid && w_err;
    dmem_error  = dmem_rvalid && w_err;
    imem_rdata  = (imem_rvalid && !w_err) ? w_rdata_fmt : 32'h0;
    dmem_rdata  = (dmem_rvalid && !w_err) ? w_rdata_fmt : 32'h0;

    mem_req   = w_req;
    mem_we    = w_req && is_store(w_op);
    mem_strb  = w_req ? w_strb : 4'b0000;
    mem_addr  = w_req ? {w_addr[31:2], 2'b00} : 32'h0;
    mem_wdata = w_req ? w_rep : 32'h0;

    // Fetch starvation guard: count data wins only while a fetch is waiting.
    if (!imem_valid || imem_ready) begin
      w_streak_nxt = '0;
    end else if (dmem_ready && (r_streak != '1)) begin
      w_streak_nxt = r_streak + STREAK_W'(1);
    end
  end

endmodule
